// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory for the M stage: wait-state insertion,
// stall request to the hazard unit and a one-cycle completion pulse.
//
//   state | meaning
//   IDLE  | no access in progress; a request is accepted here
//   WAIT  | wait-state countdown; access happens on the edge leaving WAIT
//   DONE  | completion cycle; MemValid=1, request inputs ignored
module data_mem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [XLEN-1:0] AddressM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            MemBusy,
  output logic            MemValid
);

  localparam int IDXW = $clog2(DEPTH);
  // The IDLE acceptance cycle is the first busy cycle, so WAIT spans LATENCY-1 cycles.
  localparam logic [3:0] LAT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

  stateT            state, stateNext;
  logic [3:0]       waitCnt, waitCntNext;
  logic             latWrite, latRead;
  logic [IDXW-1:0]  latIdx;
  logic [XLEN-1:0]  latData;
  logic             doAccess, accWrite, accRead;
  logic [IDXW-1:0]  accIdx;
  logic [XLEN-1:0]  accData;
  logic             req;
  logic [XLEN-1:0]  mem [DEPTH];
  logic             unusedAddrBits;

  assign req            = MemReadM | MemWriteM;
  assign unusedAddrBits = ^AddressM[XLEN-1:IDXW];

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    MemBusy     = 1'b0;
    MemValid    = 1'b0;
    doAccess    = 1'b0;
    accWrite    = latWrite;
    accRead     = latRead;
    accIdx      = latIdx;
    accData     = latData;
    case (state)
      IDLE: begin
        MemBusy = req & ~reset;
        if (req) begin
          if (LATENCY == 1) begin
            // Single busy cycle: the access commits on the acceptance edge itself.
            doAccess  = 1'b1;
            accWrite  = MemWriteM;
            accRead   = MemReadM & ~MemWriteM;
            accIdx    = AddressM[IDXW-1:0];
            accData   = WriteDataM;
            stateNext = DONE;
          end else begin
            waitCntNext = LAT_LOAD;
            stateNext   = WAIT;
          end
        end
      end
      WAIT: begin
        MemBusy = ~reset;
        if (waitCnt != 4'd0) begin
          waitCntNext = waitCnt - 4'd1;
        end else begin
          doAccess  = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        MemValid  = ~reset;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      latWrite  <= 1'b0;
      latRead   <= 1'b0;
      latIdx    <= '0;
      latData   <= '0;
      ReadDataM <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (state == IDLE && req) begin
        latWrite <= MemWriteM;
        latRead  <= MemReadM & ~MemWriteM;
        latIdx   <= AddressM[IDXW-1:0];
        latData  <= WriteDataM;
      end
      if (doAccess && accRead) ReadDataM <= mem[accIdx];
    end
  end

  // Storage has no reset; reset only blocks a write that would commit on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && doAccess && accWrite) mem[accIdx] <= accData;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=1,
// with hand-computed busy/valid profiles and load data.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd2, wr2, rd1, wr1;
  logic [31:0] addr2, data2, addr1, data1;
  logic [31:0] rdata2, rdata1;
  logic        busy2, valid2, busy1, valid1;

  int nChecks = 0;
  int nFail   = 0;
  int validCnt2 = 0;
  int vBase;

  data_mem_responder #(.XLEN(32), .DEPTH(256), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .MemReadM(rd2), .MemWriteM(wr2),
    .AddressM(addr2), .WriteDataM(data2),
    .ReadDataM(rdata2), .MemBusy(busy2), .MemValid(valid2)
  );

  data_mem_responder #(.XLEN(32), .DEPTH(256), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .MemReadM(rd1), .MemWriteM(wr1),
    .AddressM(addr1), .WriteDataM(data1),
    .ReadDataM(rdata1), .MemBusy(busy1), .MemValid(valid1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (valid2) validCnt2 <= validCnt2 + 1;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int dut, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (dut == 1) begin
      rd1 = rd; wr1 = wr; addr1 = a; data1 = d;
    end else begin
      rd2 = rd; wr2 = wr; addr2 = a; data2 = d;
    end
  endtask

  // Presents a request held stable through DONE and checks the busy/valid profile.
  task automatic access(input int dut, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic chkRd, input logic [31:0] expRd, input string tag);
    int lat;
    lat = (dut == 1) ? 1 : 2;
    drive(dut, rd, wr, a, d);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      checkVal({tag, " busy"}, {31'd0, (dut == 1) ? busy1 : busy2}, 32'd1);
      checkVal({tag, " novalid"}, {31'd0, (dut == 1) ? valid1 : valid2}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkVal({tag, " done busy"}, {31'd0, (dut == 1) ? busy1 : busy2}, 32'd0);
    checkVal({tag, " done valid"}, {31'd0, (dut == 1) ? valid1 : valid2}, 32'd1);
    if (chkRd) checkVal({tag, " rdata"}, (dut == 1) ? rdata1 : rdata2, expRd);
    @(posedge clk); #1;
    drive(dut, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(2, 1'b1, 1'b0, 32'd0, 32'd0);

    // Reset held two cycles with a load pending
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkVal("reset rdata", rdata2, 32'd0);
      checkVal("reset busy", {31'd0, busy2}, 32'd0);
      checkVal("reset valid", {31'd0, valid2}, 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    access(2, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, "post-reset load");

    // Store then load, LATENCY=2
    access(2, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'd0, "store5");
    access(2, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 32'hDEADBEEF, "load5");

    // Read and write together act as a write; ReadDataM keeps the old load
    access(2, 1'b1, 1'b1, 32'd7, 32'h00001234, 1'b1, 32'hDEADBEEF, "rdwr7");
    access(2, 1'b1, 1'b0, 32'd7, 32'd0, 1'b1, 32'h00001234, "load7");

    // Back-to-back loads: second accepted in the cycle after DONE, two pulses total
    vBase = validCnt2;
    access(2, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 32'hDEADBEEF, "b2b loadA");
    access(2, 1'b1, 1'b0, 32'd7, 32'd0, 1'b1, 32'h00001234, "b2b loadB");
    @(negedge clk);
    checkVal("b2b idle valid", {31'd0, valid2}, 32'd0);
    checkVal("b2b idle busy", {31'd0, busy2}, 32'd0);
    checkVal("b2b pulse count", 32'(validCnt2 - vBase), 32'd2);
    @(posedge clk); #1;

    // Reset during WAIT drops the pending store
    access(2, 1'b0, 1'b1, 32'd9, 32'h00000011, 1'b0, 32'd0, "store9 old");
    vBase = validCnt2;
    drive(2, 1'b0, 1'b1, 32'd9, 32'h00000022);
    @(negedge clk);
    checkVal("abort accept busy", {31'd0, busy2}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkVal("abort busy", {31'd0, busy2}, 32'd0);
    checkVal("abort valid", {31'd0, valid2}, 32'd0);
    checkVal("abort rdata", rdata2, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("abort later valid", {31'd0, valid2}, 32'd0);
    checkVal("abort pulse count", 32'(validCnt2 - vBase), 32'd0);
    @(posedge clk); #1;
    access(2, 1'b1, 1'b0, 32'd9, 32'd0, 1'b1, 32'h00000011, "load9");

    // Address wrap and single-cycle busy at LATENCY=1
    access(1, 1'b0, 1'b1, 32'h105, 32'h000000A5, 1'b0, 32'd0, "L1 store105");
    access(1, 1'b1, 1'b0, 32'h005, 32'd0, 1'b1, 32'h000000A5, "L1 load005");
    access(1, 1'b1, 1'b0, 32'hFFFF_FF05, 32'd0, 1'b1, 32'h000000A5, "L1 loadFF05");
    access(1, 1'b0, 1'b1, 32'd3, 32'h0BADF00D, 1'b0, 32'd0, "L1 store3");
    access(1, 1'b1, 1'b0, 32'd3, 32'd0, 1'b1, 32'h0BADF00D, "L1 load3");
    @(negedge clk);
    checkVal("L1 idle busy", {31'd0, busy1}, 32'd0);
    checkVal("L1 idle valid", {31'd0, valid1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
